// File: rtl/msi_bus_arbiter.sv
// Snooping-bus controller for MSI caches: round-robin arbitration, broadcast, snoop collection, write-back/fill.
// Optional snoop watchdog enabled by defining MSI_BUS_TIMEOUT_EN.
module msi_bus_arbiter #(
   parameter int N_CACHES      = 4,
   parameter int ADDR_W        = 8,
   parameter int SNOOP_TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_CACHES-1:0]          req,
   input  logic [2*N_CACHES-1:0]        req_op,
   input  logic [N_CACHES*ADDR_W-1:0]   req_addr,
   output logic [N_CACHES-1:0]          grant,
   output logic                         bus_valid,
   output logic [1:0]                   bus_op,
   output logic [ADDR_W-1:0]            bus_addr,
   output logic [$clog2(N_CACHES)-1:0]  bus_src,
   input  logic [N_CACHES-1:0]          snoop_ack,
   input  logic [N_CACHES-1:0]          snoop_flush,
   output logic                         mem_req,
   output logic                         mem_we,
   input  logic                         mem_ready,
   output logic [N_CACHES-1:0]          done,
   output logic                         bus_err,
   output logic [2:0]                   dbg_state
);
   localparam int SRC_W = $clog2(N_CACHES);
   localparam logic [1:0] OP_INV = 2'b00;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_WB, S_FILL, S_DONE} state_t;

   if (N_CACHES < 2 || N_CACHES > 8 || SNOOP_TIMEOUT < 1) begin : g_bad_cfg
      $error("msi_bus_arbiter: unsupported parameter setting");
   end

   state_t              state_q, state_d;
   logic [SRC_W-1:0]    rr_q, rr_d, src_q, src_d;
   logic [N_CACHES-1:0] grant_q, grant_d, ack_acc_q, ack_acc_d, flush_acc_q, flush_acc_d;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                err_q, err_d;

   logic                win_found;
   logic [SRC_W-1:0]    win_idx;
   logic [N_CACHES-1:0] mask, ack_all, flush_all;
   logic                covered, timeout;

   // The owner never snoops its own broadcast, so only the other caches must ack.
   assign mask      = ~grant_q;
   assign ack_all   = ack_acc_q | snoop_ack;
   assign flush_all = flush_acc_q | (snoop_ack & snoop_flush);
   assign covered   = ((ack_all & mask) == mask);

`ifdef MSI_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(SNOOP_TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign timeout = !covered && (cnt_q == CNT_W'(SNOOP_TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < N_CACHES; i++) begin
         if (!win_found && req[(int'(rr_q) + i) % N_CACHES]) begin
            win_found = 1'b1;
            win_idx   = SRC_W'((int'(rr_q) + i) % N_CACHES);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rr_q        <= '0;
         src_q       <= '0;
         grant_q     <= '0;
         ack_acc_q   <= '0;
         flush_acc_q <= '0;
         op_q        <= '0;
         addr_q      <= '0;
         err_q       <= 1'b0;
`ifdef MSI_BUS_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         src_q       <= src_d;
         grant_q     <= grant_d;
         ack_acc_q   <= ack_acc_d;
         flush_acc_q <= flush_acc_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
`ifdef MSI_BUS_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      src_d       = src_q;
      grant_d     = grant_q;
      ack_acc_d   = ack_acc_q;
      flush_acc_d = flush_acc_q;
      op_d        = op_q;
      addr_d      = addr_q;
      err_d       = err_q;
`ifdef MSI_BUS_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d          = S_BCAST;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               op_d             = req_op[2*int'(win_idx) +: 2];
               addr_d           = req_addr[ADDR_W*int'(win_idx) +: ADDR_W];
               src_d            = win_idx;
               rr_d             = (win_idx == SRC_W'(N_CACHES - 1)) ? '0 : win_idx + 1'b1;
               ack_acc_d        = '0;
               flush_acc_d      = '0;
               err_d            = 1'b0;
            end
         end
         S_BCAST: begin
            if (op_q == OP_ILL) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = S_SNOOP;
            end
`ifdef MSI_BUS_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         S_SNOOP: begin
            ack_acc_d   = ack_all;
            flush_acc_d = flush_all;
`ifdef MSI_BUS_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (covered) begin
               if (|(flush_all & mask)) state_d = S_WB;
               else if (op_q == OP_INV) state_d = S_DONE;
               else                     state_d = S_FILL;
            end else if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_WB: begin
            if (mem_ready) state_d = (op_q == OP_INV) ? S_DONE : S_FILL;
         end
         S_FILL: begin
            if (mem_ready) state_d = S_DONE;
         end
         S_DONE: begin
            state_d     = S_IDLE;
            grant_d     = '0;
            op_d        = '0;
            addr_d      = '0;
            src_d       = '0;
            ack_acc_d   = '0;
            flush_acc_d = '0;
            err_d       = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      grant     = grant_q;
      bus_valid = (state_q == S_BCAST);
      bus_op    = op_q;
      bus_addr  = addr_q;
      bus_src   = src_q;
      mem_req   = (state_q == S_WB) || (state_q == S_FILL);
      mem_we    = (state_q == S_WB);
      done      = (state_q == S_DONE) ? grant_q : '0;
      bus_err   = (state_q == S_DONE) && err_q;
      dbg_state = state_q;
   end
endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed bench for msi_bus_arbiter; completions are scored against an expected queue.
// Timeout expectations follow MSI_BUS_TIMEOUT_EN.
module tb_msi_bus_arbiter;
   localparam int N = 4;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [2*N-1:0] req_op;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]  grant;
   logic          bus_valid;
   logic [1:0]    bus_op;
   logic [AW-1:0] bus_addr;
   logic [1:0]    bus_src;
   logic [N-1:0]  snoop_ack;
   logic [N-1:0]  snoop_flush;
   logic          mem_req;
   logic          mem_we;
   logic          mem_ready;
   logic [N-1:0]  done;
   logic          bus_err;
   logic [2:0]    dbg_state;

   msi_bus_arbiter #(.N_CACHES(N), .ADDR_W(AW), .SNOOP_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
      .grant(grant), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
      .bus_src(bus_src), .snoop_ack(snoop_ack), .snoop_flush(snoop_flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready), .done(done),
      .bus_err(bus_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Completion record: {done vector, bus_err, saw write-back, saw fill}
   logic [6:0] exp_q[$];
   logic [6:0] exp_e;
   logic       saw_wb, saw_fill;

   int         nbv, gchg, lat;
   logic [1:0] bv_op, bv_src;
   logic [AW-1:0] bv_addr;
   logic [N-1:0] bv_grant, g1;
   logic [AW-1:0] addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         saw_wb   = 1'b0;
         saw_fill = 1'b0;
      end else begin
         if (mem_req) begin
            if (mem_we) saw_wb = 1'b1;
            else        saw_fill = 1'b1;
         end
         if (|done) begin
            if (exp_q.size() == 0) begin
               check("done_unexpected", 32'(done), 32'd0);
            end else begin
               exp_e = exp_q.pop_front();
               check("completion", 32'({done, bus_err, saw_wb, saw_fill}), 32'(exp_e));
            end
            saw_wb   = 1'b0;
            saw_fill = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic idle_step();
      step();
      check("grant_released", 32'(grant), 32'd0);
   endtask

   // ack_sched holds, per cache, the sample cycle from which its ack is high (255 = never).
   task automatic run_txn(input logic [31:0] ack_sched, input int mem_delay, input int budget, output int lat_o);
      int   mem_cnt;
      logic prev_req, prev_we;
      lat_o = -1; nbv = 0; gchg = 0; mem_cnt = 0; prev_req = 1'b0; prev_we = 1'b0;
      g1 = '0;
      for (int i = 0; i < N; i++) snoop_ack[i] = (ack_sched[8*i +: 8] == 8'd0);
      for (int c = 1; c <= budget; c++) begin
         step();
         if (bus_valid) begin
            nbv++;
            bv_op = bus_op; bv_addr = bus_addr; bv_src = bus_src; bv_grant = grant;
         end
         if (c == 1) g1 = grant;
         else if (grant !== g1) gchg++;
         if (mem_req) begin
            if (!prev_req || mem_we !== prev_we) mem_cnt = 0;
            mem_cnt++;
         end else begin
            mem_cnt = 0;
         end
         prev_req = mem_req;
         prev_we  = mem_we;
         mem_ready = mem_req && (mem_cnt > mem_delay);
         for (int i = 0; i < N; i++) snoop_ack[i] = (c >= int'(ack_sched[8*i +: 8]));
         if (|done) begin
            lat_o     = c;
            req       = req & ~done;
            mem_ready = 1'b0;
            snoop_ack = '0;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req = '0; req_op = '0; req_addr = '0;
      snoop_ack = '0; snoop_flush = '0; mem_ready = 1'b0;
      step(); step();
      check("reset_outputs", 32'({grant, bus_valid, bus_op, bus_addr, bus_src, mem_req, mem_we, done, bus_err, dbg_state}), 32'd0);
      reset = 1'b0;
      step();

      // Cache 2 read miss, acks immediate, memory ready after 2 wait cycles
      addr = 8'($urandom_range(0, 255));
      req_op = 8'b00_10_00_00; req_addr = '0; req_addr[2*AW +: AW] = addr; req = 4'b0100;
      exp_q.push_back({4'b0100, 1'b0, 1'b0, 1'b1});
      run_txn(32'h00000000, 2, 20, lat);
      check("rm_latency", 32'(lat), 32'd6);
      check("rm_bus_valid_count", 32'(nbv), 32'd1);
      check("rm_bus_op", 32'(bv_op), 32'd2);
      check("rm_bus_addr", 32'(bv_addr), 32'(addr));
      check("rm_bus_src", 32'(bv_src), 32'd2);
      check("rm_grant", 32'(bv_grant), 32'b0100);
      check("rm_grant_stable", 32'(gchg), 32'd0);
      idle_step();

      // Round robin from reset: 0 and 1 contend, expect order 0,1,0
      apply_reset();
      req_op = 8'h00; req = 4'b0011;
      exp_q.push_back({4'b0001, 3'b000});
      run_txn(32'h00000000, 0, 20, lat);
      check("rr1_src", 32'(bv_src), 32'd0);
      check("inv_latency", 32'(lat), 32'd3);
      req[0] = 1'b1;
      exp_q.push_back({4'b0010, 3'b000});
      idle_step();
      run_txn(32'h00000000, 0, 20, lat);
      check("rr2_src", 32'(bv_src), 32'd1);
      req[1] = 1'b1;
      exp_q.push_back({4'b0001, 3'b000});
      idle_step();
      run_txn(32'h00000000, 0, 20, lat);
      check("rr3_src", 32'(bv_src), 32'd0);
      req = '0;
      idle_step();

      // Cache 1 write miss, cache 3 flushes: WB then FILL
      req_op = 8'b00_00_01_00; snoop_flush = 4'b1000; req = 4'b0010;
      exp_q.push_back({4'b0010, 1'b0, 1'b1, 1'b1});
      run_txn(32'h00000000, 0, 20, lat);
      check("wm_flush_latency", 32'(lat), 32'd5);
      check("wm_bus_op", 32'(bv_op), 32'd1);
      snoop_flush = '0;
      idle_step();

      // Cache 0 invalidate, acks staggered at cycles 2,4,6
      req_op = 8'h00; req = 4'b0001;
      exp_q.push_back({4'b0001, 3'b000});
      run_txn(32'h060402FF, 0, 20, lat);
      check("inv_stagger_latency", 32'(lat), 32'd7);
      idle_step();

      // Cache 2 invalidate, cache 0 flushes: WB only
      req_op = 8'h00; snoop_flush = 4'b0001; req = 4'b0100;
      exp_q.push_back({4'b0100, 1'b0, 1'b1, 1'b0});
      run_txn(32'h00000000, 0, 20, lat);
      check("inv_flush_latency", 32'(lat), 32'd4);
      snoop_flush = '0;
      idle_step();

      // Cache 3 illegal op
      req_op = 8'b11_00_00_00; req = 4'b1000;
      exp_q.push_back({4'b1000, 1'b1, 2'b00});
      run_txn(32'hFFFFFFFF, 0, 20, lat);
      check("ill_latency", 32'(lat), 32'd2);
      check("ill_bus_valid_count", 32'(nbv), 32'd1);
      check("ill_bus_op", 32'(bv_op), 32'd3);
      idle_step();

      // Cache 1 read miss with cache 3 silent until cycle 22
      req_op = 8'b00_00_10_00; req = 4'b0010;
`ifdef MSI_BUS_TIMEOUT_EN
      exp_q.push_back({4'b0010, 1'b1, 2'b00});
      run_txn(32'h16000000, 0, 40, lat);
      check("timeout_latency", 32'(lat), 32'd18);
`else
      exp_q.push_back({4'b0010, 1'b0, 1'b0, 1'b1});
      run_txn(32'h16000000, 0, 40, lat);
      check("late_ack_latency", 32'(lat), 32'd24);
`endif
      idle_step();

      // Reset while in FILL discards the transaction
      req_op = 8'b00_10_00_00; req = 4'b0100; snoop_ack = 4'b1111; mem_ready = 1'b0;
      step(); step(); step();
      check("in_fill", 32'({mem_req, mem_we}), 32'b10);
      reset = 1'b1; req = '0; snoop_ack = '0;
      step();
      check("reset_in_fill_outputs", 32'({grant, bus_valid, bus_op, bus_addr, bus_src, mem_req, mem_we, done, bus_err, dbg_state}), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_done_after_reset", 32'(done), 32'd0);
      end

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/msi_bus_arbiter.md
# msi_bus_arbiter

Snooping-bus controller for the MSI coherence subsystem. It arbitrates among N per-cache MSI controllers that need to issue a bus transaction (invalidate, write miss, read miss). It broadcasts the winner's transaction and collects snoop acknowledgements and write-back flushes from the other caches. It then sequences the memory write-back and fill before signalling completion to the requester.

## Interface
- N_CACHES, 4: number of cache controllers on the bus (2..8).
- ADDR_W, 8: block address width.
- SNOOP_TIMEOUT, 16: snoop-wait limit in cycles (used only with MSI_BUS_TIMEOUT_EN).

- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_CACHES  per-cache bus request; held with op/addr until done.
- req_op  in  2*N_CACHES  per-cache bus op: 00 BUS_INVALIDATE, 01 BUS_WRITE_MISS, 10 BUS_READ_MISS, 11 illegal.
- req_addr  in  N_CACHES*ADDR_W  per-cache block address.
- grant  out  N_CACHES  one-hot owner of the bus.
- bus_valid  out  1  one-cycle broadcast strobe.
- bus_op  out  2  broadcast op.
- bus_addr  out  ADDR_W  broadcast address.
- bus_src  out  $clog2(N_CACHES)  index of the owner.
- snoop_ack  in  N_CACHES  snooper has processed the broadcast; level, may arrive any cycle after bus_valid.
- snoop_flush  in  N_CACHES  qualifies snoop_ack: snooper held MODIFIED and must write back.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write-back, 0 = fill read.
- mem_ready  in  1  memory completes the current access this cycle.
- done  out  N_CACHES  one-cycle completion pulse to the owner.
- bus_err  out  1  one-cycle pulse: illegal op or snoop timeout.

## Operation
- States: IDLE, BCAST, SNOOP, WB, FILL, DONE.
- Reset: state IDLE, rr pointer 0, ack/flush accumulators cleared, every output 0.
- IDLE: if any req, pick winner round-robin, starting at the rr pointer. Next: BCAST. Latch grant, bus_op, bus_addr and bus_src. rr pointer = winner+1 mod N_CACHES.
- BCAST: bus_valid=1 for exactly this cycle. If op==11, next is DONE with bus_err pulsed in DONE. Otherwise next is SNOOP.
- SNOOP: OR snoop_ack and snoop_ack&snoop_flush into sticky accumulators. Expected mask = all caches except bus_src; the owner's ack is ignored. When accumulated|current covers the mask:
  - any flush -> WB;
  - else op==INVALIDATE -> DONE;
  - else -> FILL.
- WB: mem_req=1, mem_we=1 until mem_ready. Then INVALIDATE -> DONE; other ops -> FILL.
- FILL: mem_req=1, mem_we=0 until mem_ready. Next: DONE.
- DONE: done[bus_src]=1 for one cycle. Clear grant, bus_op, bus_addr, bus_src and the accumulators. Next: IDLE.
- grant stays stable from BCAST through DONE inclusive.
- mem_ready is ignored outside WB/FILL. snoop_ack is ignored outside SNOOP.
- A req dropped mid-transaction does not abort it.
- Requests arriving during a transaction wait. New arbitration happens only in IDLE, so there is at least one IDLE cycle between transactions.

## Timing
- Request seen in IDLE at edge t: grant and bus_valid at t+1.
- Earliest SNOOP exit is t+2, when all acks are present at t+2.
- Minimum latency, req to done:
  - INVALIDATE without flush: 3 cycles.
  - Miss without flush and mem_ready immediate: 4 cycles.
  - Each flush adds at least 1 WB cycle.
- All outputs are registered (Moore). None is combinational from inputs.
- Reset asserted in any state: at the next edge all outputs are 0, state is IDLE, and the pending transaction is discarded without a done pulse.

## Configuration
- MSI_BUS_TIMEOUT_EN defined:
  - Counter runs in SNOOP, cleared on entry.
  - After SNOOP_TIMEOUT cycles without a full ack mask, go to DONE and pulse bus_err with done.
  - No WB or FILL is issued for that transaction.
- Undefined: SNOOP waits indefinitely, bus_err is asserted only for illegal op, and no counter logic exists.

## Test plan
- Cache 2 READ_MISS, others ack at once, no flush, mem_ready after 2 cycles -> grant=0100, single bus_valid with op=10, one FILL (mem_we=0), done[2] at req+6.
- Caches 0 and 1 request simultaneously from reset -> cache 0 served first. Repeated simultaneous requests alternate 0,1,0.
- Cache 1 WRITE_MISS, cache 3 acks with snoop_flush -> WB (mem_we=1) then FILL, done[1], grant released.
- Cache 0 INVALIDATE with acks staggered over 5 cycles -> no mem_req, done[0] exactly one cycle after the last ack is seen.
- op=11 from cache 3 -> bus_valid pulse, then done[3] with bus_err=1, no mem_req.
- Reset in FILL -> next cycle all outputs 0, no done. With MSI_BUS_TIMEOUT_EN and one snooper silent -> bus_err + done after 16 SNOOP cycles.
